serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial subtractor (a - b, LSB first) built on one reused
//               full-adder slice, with IDLE/RUN/DONE handshake control.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_carry;
    logic             r_c_out;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_b_inv;
    logic             w_sum;
    logic             w_carry_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    // Single full-adder slice: a + ~b + carry, one bit per RUN cycle
    assign w_b_inv     = ~r_b_sh[0];
    assign w_sum       = r_a_sh[0] ^ w_b_inv ^ r_carry;
    assign w_carry_nxt = (r_a_sh[0] & w_b_inv) | (r_a_sh[0] & r_carry) | (w_b_inv & r_carry);
    assign w_last      = (r_cnt == c_last_bit);
    assign w_res_nxt   = {w_sum, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run:  if (w_last) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        ready = (r_state == c_st_idle);
        busy  = (r_state == c_st_run);
        done  = (r_state == c_st_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                c_st_run: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_res   <= w_res_nxt;
                    r_carry <= w_carry_nxt;
                    r_cnt   <= r_cnt + 1'b1;
                    // On the MSB slice r_carry is the MSB carry-in, so ovf = cin ^ cout
                    if (w_last) begin
                        r_diff  <= w_res_nxt;
                        r_c_out <= w_carry_nxt;
                        r_ovf   <= r_carry ^ w_carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff  = r_diff;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Self-checking bench for serial_sub_ctrl (WIDTH=8) against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             c_out;
    logic             ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Reference: {ovf, c_out, diff} from plain integer arithmetic
    function automatic logic [9:0] ref_sub(input logic [7:0] x, input logic [7:0] y);
        int sx;
        int sy;
        int sd;
        logic [7:0] d;
        logic c;
        logic o;
        d  = 8'((int'(x) - int'(y)) & 255);
        c  = (x >= y);
        sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
        sd = sx - sy;
        o  = (sd > 127) || (sd < -128);
        return {o, c, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ready, issues one request, scrambles operands during
    // RUN and counts samples until done. lat = samples after accept until done.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                         output int lat, output int busy_cnt, output bit to);
        int n;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        a = ia;
        b = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        to = 1'b0;
        while (!done && lat < 50) begin
            if (busy) busy_cnt++;
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            lat++;
        end
        if (!done) to = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = 8'hA5;
        b = 8'h3C;
        tick();
        tick();
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 100", {ready, busy, done});
        end
        n_cmp++;
        if ({diff, c_out, ovf} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got diff=%h c=%b o=%b want 0/0/0", diff, c_out, ovf);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [7:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'h80};
        logic [7:0] vb [4] = '{8'h03, 8'h05, 8'h00, 8'h01};
        logic [9:0] ve [4] = '{{2'b01, 8'h02}, {2'b00, 8'hFE}, {2'b01, 8'h00}, {2'b11, 8'h7F}};
        int lat;
        int bc;
        bit to;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], lat, bc, to);
            n_cmp++;
            if (to || lat != WIDTH + 1) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d timeout=%0b want %0d", i, lat, to, WIDTH + 1);
            end
            n_cmp++;
            if (bc != WIDTH) begin
                n_fail++;
                $display("FAIL dir_busy_cycles[%0d]: got %0d want %0d", i, bc, WIDTH);
            end
            n_cmp++;
            if ({ovf, c_out, diff} !== ve[i]) begin
                n_fail++;
                $display("FAIL dir_result[%0d]: got o=%b c=%b d=%h want %h", i, ovf, c_out, diff, ve[i]);
            end
            tick();
            n_cmp++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                n_fail++;
                $display("FAIL dir_done_pulse[%0d]: got done=%b ready=%b want 0/1", i, done, ready);
            end
            for (int k = 0; k < 3; k++) begin
                a = 8'($urandom);
                b = 8'($urandom);
                tick();
            end
            n_cmp++;
            if ({ovf, c_out, diff} !== ve[i]) begin
                n_fail++;
                $display("FAIL dir_hold[%0d]: got o=%b c=%b d=%h want %h", i, ovf, c_out, diff, ve[i]);
            end
        end
        do_op(8'h7F, 8'hFF, lat, bc, to);
        n_cmp++;
        if (to || {ovf, c_out, diff} !== {2'b10, 8'h80}) begin
            n_fail++;
            $display("FAIL dir_7f_ff: got o=%b c=%b d=%h timeout=%0b want o=1 c=0 d=80", ovf, c_out, diff, to);
        end
        tick();
    endtask

    // start held high; fresh random operands every cycle. Acceptances are
    // expected at edges 0,10,20,30 and done pulses 8 edges after each.
    task automatic test_back_to_back();
        logic [7:0] av [40];
        logic [7:0] bv [40];
        logic [9:0] e;
        int n;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 40; i++) begin
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
        end
        for (int i = 0; i < 40; i++) begin
            a = av[i];
            b = bv[i];
            start = 1'b1;
            tick();
            n_cmp++;
            if (done !== ((i % 10) == 8)) begin
                n_fail++;
                $display("FAIL b2b_done_at[%0d]: got %b want %b", i, done, (i % 10) == 8);
            end
            if ((i % 10) == 8) begin
                e = ref_sub(av[i-8], bv[i-8]);
                n_cmp++;
                if ({ovf, c_out, diff} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got o=%b c=%b d=%h want %h", i, ovf, c_out, diff, e);
                end
            end
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int bc;
        bit to;
        logic [9:0] e;
        bit saw_done;
        do_op(8'h80, 8'h01, lat, bc, to);
        tick();
        a = 8'h5A;
        b = 8'h21;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL midrst_flags: got %b want 100", {ready, busy, done});
        end
        n_cmp++;
        if ({diff, c_out, ovf} !== 10'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got diff=%h c=%b o=%b want 0", diff, c_out, ovf);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_done: got done pulse, want none");
        end
        do_op(8'h5A, 8'h21, lat, bc, to);
        e = ref_sub(8'h5A, 8'h21);
        n_cmp++;
        if (to || lat != WIDTH + 1 || {ovf, c_out, diff} !== e) begin
            n_fail++;
            $display("FAIL midrst_restart: got o=%b c=%b d=%h lat=%0d want %h lat=%0d", ovf, c_out, diff, lat, e, WIDTH + 1);
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        int bc;
        bit to;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [9:0] e;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 16 == 0) rb = ra;
            do_op(ra, rb, lat, bc, to);
            e = ref_sub(ra, rb);
            n_cmp++;
            if (to || {ovf, c_out, diff} !== e) begin
                n_fail++;
                $display("FAIL rand[%0d] a=%h b=%h: got o=%b c=%b d=%h timeout=%0b want %h", i, ra, rb, ovf, c_out, diff, to, e);
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
